mem_arbiter: RTL

Two-port arbiter that shares a single unified instruction/data memory port between the fetch stage and the load/store (MEM) stage of the RV32I core. It accepts one request at a time from either side, issues it to memory with a req/ack handshake, and returns read data or write completion to the winning requester. Data accesses win by default. A starvation counter guarantees fetch progress under sustained load/store traffic.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of mem_arbiter in one bundle.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one unified memory port between instruction fetch and load/store.
// Data wins by default; a streak counter forces a fetch after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4    // must be >= 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]          state;
    logic [STREAK_W-1:0] streak;

    logic                if_gnt_q;
    logic                if_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                d_gnt_q;
    logic                d_rvalid_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [3:0]          mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                grant_d;
    logic                grant_if;

    // A waiting fetch only overrides data once the data streak has reached the limit.
    always_comb begin
        grant_d  = bus.d_req && !(bus.if_req && (streak == STREAK_LIMIT));
        grant_if = bus.if_req && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= BUSY_D;
                        d_gnt_q     <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_be_q    <= bus.d_be;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (grant_if) begin
                        state       <= BUSY_IF;
                        if_gnt_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'hF;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end

                    // Only data wins that keep a fetch waiting lengthen the streak.
                    if (!bus.if_req || grant_if) begin
                        streak <= '0;
                    end else if (grant_d && (streak != STREAK_LIMIT)) begin
                        streak <= streak + 1'b1;
                    end
                end

                BUSY_IF, BUSY_D: begin
                    if (bus.mem_ack) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.mem_rdata;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
